// File: rtl/rf_alu_pkg.sv
// Shared encodings for the register-file / ALU datapath: opcodes, writeback sources,
// instruction field positions and PSW bit order.
package rf_alu_pkg;

  localparam int RF_AW = 3;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_ADC   = 3'b001,
    ALU_SUB   = 3'b010,
    ALU_SBB   = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_XOR   = 3'b110,
    ALU_PASSA = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_DATA = 2'b00,
    WB_SUM  = 2'b01,
    WB_LI   = 2'b10,
    WB_SUMX = 2'b11
  } wb_src_e;

  localparam int INS_RD_LSB = 8;
  localparam int INS_RA_LSB = 5;
  localparam int INS_RB_LSB = 2;

  // Packed PSW order used when the flags are viewed as a nibble {C,Z,N,V}
  localparam int PSW_C = 3;
  localparam int PSW_Z = 2;
  localparam int PSW_N = 1;
  localparam int PSW_V = 0;

endpackage

// File: rtl/rf_bypass_regfile.sv
// 8-entry register file, two combinational read ports with write-through bypass,
// one write port, synchronous active-low clear.
module rf_bypass_regfile
  import rf_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RF_AW-1:0]  ra_a,
  input  logic [RF_AW-1:0]  ra_b,
  input  logic [RF_AW-1:0]  wa,
  input  logic              we,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd_a = (we && wa == ra_a) ? wd : mem[ra_a];
  assign rd_b = (we && wa == ra_b) ? wd : mem[ra_b];

endmodule

// File: rtl/rf_alu_pipe.sv
// ID-stage register reads, ID/EXE operand buffer, ALU and PSW for the multicycle core.
// Sum is combinational from the buffer; the controller sequences every load and write.
module rf_alu_pipe
  import rf_alu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NREG       = 8,
  parameter int IMM_SIGNED = 0
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [15:0]       Ins,
  input  logic [DATA_W-1:0] WBData,
  input  logic              WBRF,
  input  logic [1:0]        WBresource,
  input  logic              RBresource,
  input  logic              OprandB,
  input  logic              LI,
  input  logic              Buff_IDEXE,
  input  logic [2:0]        ALUop,
  input  logic              Flag,
  output logic [DATA_W-1:0] Rm,
  output logic [DATA_W-1:0] Rd,
  output logic [DATA_W-1:0] OutR,
  output logic [DATA_W-1:0] LI_EXE,
  output logic [DATA_W-1:0] Sum,
  output logic              C,
  output logic              Z,
  output logic              N,
  output logic              V
);

  logic [RF_AW-1:0]  ra_a, ra_b, wa;
  logic [DATA_W-1:0] wb_val, imm_ext, li_val, opa, opb;
  logic [4:0]        imm5;
  logic [7:0]        imm8;
  logic              ins_unused;

  assign ra_a = Ins[INS_RA_LSB +: RF_AW];
  assign wa   = Ins[INS_RD_LSB +: RF_AW];
  assign ra_b = RBresource ? Ins[INS_RD_LSB +: RF_AW] : Ins[INS_RB_LSB +: RF_AW];
  assign imm5 = Ins[4:0];
  assign imm8 = Ins[7:0];
  assign ins_unused = ^Ins[15:11];

  always_comb begin
    wb_val = WBData;
    case (wb_src_e'(WBresource))
      WB_DATA: wb_val = WBData;
      WB_LI:   wb_val = LI_EXE;
      default: wb_val = Sum;
    endcase
  end

  rf_bypass_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clk  (clk),
    .rst_n(Reset),
    .ra_a (ra_a),
    .ra_b (ra_b),
    .wa   (wa),
    .we   (WBRF),
    .wd   (wb_val),
    .rd_a (Rm),
    .rd_b (Rd)
  );

  assign imm_ext = (IMM_SIGNED != 0) ? {{(DATA_W-5){imm5[4]}}, imm5} : {{(DATA_W-5){1'b0}}, imm5};

  // LHI keeps everything of DataB except bits [15:8], which take imm8
  assign li_val = LI ? ((Rd & ~DATA_W'(16'hFF00)) | (DATA_W'(imm8) << 8)) : DATA_W'(imm8);

  always_ff @(posedge clk) begin
    if (!Reset) begin
      opa    <= '0;
      opb    <= '0;
      LI_EXE <= '0;
    end else if (Buff_IDEXE) begin
      opa    <= Rm;
      opb    <= OprandB ? imm_ext : Rd;
      LI_EXE <= li_val;
    end
  end

  assign OutR = opa;

  logic [DATA_W:0] res;
  logic [DATA_W:0] cin_w;
  logic            is_add, is_sub, c_nx, v_nx;

  assign cin_w = {{DATA_W{1'b0}}, C};

  always_comb begin
    res    = '0;
    is_add = 1'b0;
    is_sub = 1'b0;
    case (alu_op_e'(ALUop))
      ALU_ADD:   begin res = {1'b0, opa} + {1'b0, opb};         is_add = 1'b1; end
      ALU_ADC:   begin res = {1'b0, opa} + {1'b0, opb} + cin_w; is_add = 1'b1; end
      ALU_SUB:   begin res = {1'b0, opa} - {1'b0, opb};         is_sub = 1'b1; end
      ALU_SBB:   begin res = {1'b0, opa} - {1'b0, opb} - cin_w; is_sub = 1'b1; end
      ALU_AND:   res = {1'b0, opa & opb};
      ALU_OR:    res = {1'b0, opa | opb};
      ALU_XOR:   res = {1'b0, opa ^ opb};
      default:   res = {1'b0, opa};
    endcase
    // Bit DATA_W is carry-out for adds and borrow for subtracts
    c_nx = (is_add || is_sub) && res[DATA_W];
    v_nx = (is_add && (opa[DATA_W-1] == opb[DATA_W-1]) && (res[DATA_W-1] != opa[DATA_W-1])) ||
           (is_sub && (opa[DATA_W-1] != opb[DATA_W-1]) && (res[DATA_W-1] != opa[DATA_W-1]));
  end

  assign Sum = res[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!Reset) begin
      {C, Z, N, V} <= 4'b0000;
    end else if (Flag) begin
      C <= c_nx;
      Z <= (Sum == '0);
      N <= Sum[DATA_W-1];
      V <= v_nx;
    end
  end

endmodule

// File: tb/tb_rf_alu_pipe.sv
// Directed bench: table of ALU vectors plus hand sequences for reset, writeback,
// bypass, load-immediate and immediate extension (zero- and sign-extended instances).
module tb_rf_alu_pipe;
  import rf_alu_pkg::*;

  logic        clk = 1'b0;
  logic        Reset, WBRF, RBresource, OprandB, LI, Buff_IDEXE, Flag;
  logic [15:0] Ins, WBData;
  logic [1:0]  WBresource;
  logic [2:0]  ALUop;

  logic [15:0] Rm, Rd, OutR, LI_EXE, Sum;
  logic        C, Z, N, V;
  logic [15:0] sx_rm, sx_rd, sx_outr, sx_li, sx_sum;
  logic        sx_c, sx_z, sx_n, sx_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_alu_pipe #(.DATA_W(16), .NREG(8), .IMM_SIGNED(0)) u_zx (
    .clk(clk), .Reset(Reset), .Ins(Ins), .WBData(WBData), .WBRF(WBRF),
    .WBresource(WBresource), .RBresource(RBresource), .OprandB(OprandB), .LI(LI),
    .Buff_IDEXE(Buff_IDEXE), .ALUop(ALUop), .Flag(Flag),
    .Rm(Rm), .Rd(Rd), .OutR(OutR), .LI_EXE(LI_EXE), .Sum(Sum),
    .C(C), .Z(Z), .N(N), .V(V)
  );

  rf_alu_pipe #(.DATA_W(16), .NREG(8), .IMM_SIGNED(1)) u_sx (
    .clk(clk), .Reset(Reset), .Ins(Ins), .WBData(WBData), .WBRF(WBRF),
    .WBresource(WBresource), .RBresource(RBresource), .OprandB(OprandB), .LI(LI),
    .Buff_IDEXE(Buff_IDEXE), .ALUop(ALUop), .Flag(Flag),
    .Rm(sx_rm), .Rd(sx_rd), .OutR(sx_outr), .LI_EXE(sx_li), .Sum(sx_sum),
    .C(sx_c), .Z(sx_z), .N(sx_n), .V(sx_v)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] sum;
    logic [3:0]  czn_v;
  } vec_t;

  vec_t vt [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] addr, input logic [15:0] val);
    Ins        = {5'b0, addr, 8'h00};
    WBData     = val;
    WBresource = 2'b00;
    WBRF       = 1'b1;
    tick();
    WBRF = 1'b0;
  endtask

  // Ra=R1, Rb=R2, Rd=R3
  task automatic load_r1_r2(input logic [15:0] a, input logic [15:0] b);
    wr(3'd1, a);
    wr(3'd2, b);
    Ins        = 16'h0328;
    RBresource = 1'b0;
    OprandB    = 1'b0;
    Buff_IDEXE = 1'b1;
    tick();
    Buff_IDEXE = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{16'h7FFF, 16'h0001, ALU_ADD,   16'h8000, 4'b0011};
    vt[1]  = '{16'h0001, 16'h0002, ALU_SUB,   16'hFFFF, 4'b1010};
    vt[2]  = '{16'h0005, 16'h0003, ALU_SBB,   16'h0001, 4'b0000};
    vt[3]  = '{16'h1234, 16'h1234, ALU_SUB,   16'h0000, 4'b0100};
    vt[4]  = '{16'hFFFF, 16'h0001, ALU_ADD,   16'h0000, 4'b1100};
    vt[5]  = '{16'h0001, 16'h0001, ALU_ADC,   16'h0003, 4'b0000};
    vt[6]  = '{16'h8000, 16'h0001, ALU_SUB,   16'h7FFF, 4'b0001};
    vt[7]  = '{16'hF0F0, 16'h3C3C, ALU_AND,   16'h3030, 4'b0000};
    vt[8]  = '{16'hF0F0, 16'h0F0F, ALU_OR,    16'hFFFF, 4'b0010};
    vt[9]  = '{16'hAAAA, 16'hAAAA, ALU_XOR,   16'h0000, 4'b0100};
    vt[10] = '{16'h8001, 16'h1234, ALU_PASSA, 16'h8001, 4'b0010};
    vt[11] = '{16'hFFFF, 16'hFFFF, ALU_ADD,   16'hFFFE, 4'b1010};
    vt[12] = '{16'h0000, 16'h0000, ALU_SBB,   16'hFFFF, 4'b1010};

    Reset = 1'b0; WBRF = 1'b0; RBresource = 1'b0; OprandB = 1'b0; LI = 1'b0;
    Buff_IDEXE = 1'b0; Flag = 1'b0; Ins = 16'h0000; WBData = 16'h0000;
    WBresource = 2'b00; ALUop = 3'b000;
    tick(); tick();
    Reset = 1'b1;
    #1;
    chk("rst_rm", Rm, 16'h0000);
    chk("rst_outr", OutR, 16'h0000);
    chk("rst_li", LI_EXE, 16'h0000);
    chk("rst_psw", {C, Z, N, V}, 4'b0000);

    // ALU table; carry-in of ADC/SBB rows comes from the previous row's C
    for (int i = 0; i < 13; i++) begin
      load_r1_r2(vt[i].a, vt[i].b);
      ALUop = vt[i].op;
      Flag  = 1'b1;
      #1;
      chk($sformatf("vec%0d_sum", i), Sum, vt[i].sum);
      chk($sformatf("vec%0d_outr", i), OutR, vt[i].a);
      tick();
      Flag = 1'b0;
      chk($sformatf("vec%0d_psw", i), {C, Z, N, V}, vt[i].czn_v);
    end

    // Writeback of Sum through both Sum encodings
    load_r1_r2(16'h7FFF, 16'h0001);
    ALUop = ALU_ADD; WBresource = 2'b01; WBRF = 1'b1;
    tick();
    WBRF = 1'b0;
    Ins = 16'h0528; WBresource = 2'b11; WBRF = 1'b1;
    tick();
    WBRF = 1'b0;
    Ins = 16'h0060; #1;
    chk("wb_sum_r3", Rm, 16'h8000);
    Ins = 16'h00A0; #1;
    chk("wb_sumx_r5", Rm, 16'h8000);

    // Write-through bypass into the buffer
    wr(3'd1, 16'h1111);
    Ins = 16'h0120; WBData = 16'hBEEF; WBresource = 2'b00; WBRF = 1'b1;
    RBresource = 1'b1; Buff_IDEXE = 1'b1;
    #1;
    chk("byp_rm", Rm, 16'hBEEF);
    chk("byp_rd", Rd, 16'hBEEF);
    tick();
    WBRF = 1'b0; Buff_IDEXE = 1'b0;
    #1;
    chk("byp_outr", OutR, 16'hBEEF);
    chk("byp_rf", Rm, 16'hBEEF);

    // Load immediate, both forms, then write back LHI result
    wr(3'd4, 16'h00AA);
    Ins = 16'h0455; RBresource = 1'b1; LI = 1'b1; Buff_IDEXE = 1'b1;
    tick();
    chk("lhi", LI_EXE, 16'h55AA);
    LI = 1'b0;
    tick();
    chk("lli", LI_EXE, 16'h0055);
    LI = 1'b1;
    tick();
    Buff_IDEXE = 1'b0; WBresource = 2'b10; WBRF = 1'b1;
    tick();
    WBRF = 1'b0;
    #1;
    chk("li_wb_r4", Rd, 16'h55AA);

    // imm5 extension: zero-extended vs sign-extended instance
    wr(3'd1, 16'h0010);
    Ins = 16'h003F; OprandB = 1'b1; RBresource = 1'b0; Buff_IDEXE = 1'b1;
    tick();
    Buff_IDEXE = 1'b0; ALUop = ALU_ADD; Flag = 1'b1;
    #1;
    chk("imm_zx_sum", Sum, 16'h002F);
    chk("imm_sx_sum", sx_sum, 16'h000F);
    tick();
    Flag = 1'b0; OprandB = 1'b0;
    chk("imm_zx_c", C, 1'b0);
    chk("imm_sx_c", sx_c, 1'b1);

    // Reset dominates a simultaneous write, buffer load and flag update
    wr(3'd3, 16'h1234);
    Ins = 16'h0060; #1;
    chk("pre_rst_r3", Rm, 16'h1234);
    Ins = 16'h0360; WBData = 16'h5555; WBRF = 1'b1; Buff_IDEXE = 1'b1; Flag = 1'b1;
    ALUop = ALU_SUB; LI = 1'b1;
    Reset = 1'b0;
    tick();
    Reset = 1'b1; WBRF = 1'b0; Buff_IDEXE = 1'b0; Flag = 1'b0;
    #1;
    chk("rst2_r3", Rm, 16'h0000);
    chk("rst2_outr", OutR, 16'h0000);
    chk("rst2_li", LI_EXE, 16'h0000);
    chk("rst2_psw", {C, Z, N, V}, 4'b0000);
    chk("rst2_sx_psw", {sx_c, sx_z, sx_n, sx_v}, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
